// File: rtl/cpt_capture8.sv
// Event timestamp capture: latches cpt on evt rising edges and reports the interval to the previous capture.
// Define CPT_CAPTURE_SYNC_EN to pass evt through a 2-flop synchroniser (capture 2 cycles later).
module cpt_capture8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       activate,
  input  logic [7:0] cpt,
  input  logic       evt,
  input  logic       rd,
  output logic [7:0] cap,
  output logic [7:0] delta,
  output logic       valid,
  output logic       ovr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] delta_q, delta_d;
  logic [7:0] ref_q, ref_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;

  logic s0;
  logic s0_real;
  logic s1_q;
  logic rdy_q;
  logic rise;
  logic capture;

`ifdef CPT_CAPTURE_SYNC_EN
  logic meta_q, s0_q, fill1_q, fill2_q;

  // fill flags mark when s0 holds a genuine sample of evt rather than its reset value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      s0_q    <= 1'b0;
      fill1_q <= 1'b0;
      fill2_q <= 1'b0;
    end else begin
      meta_q  <= evt;
      s0_q    <= meta_q;
      fill1_q <= 1'b1;
      fill2_q <= fill1_q;
    end
  end

  assign s0      = s0_q;
  assign s0_real = fill2_q;
`else
  assign s0      = evt;
  assign s0_real = 1'b1;
`endif

  // rdy_q blocks a capture until evt has been seen low, so a level held across reset is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      s1_q  <= s0;
      rdy_q <= rdy_q | (s0_real & ~s0);
    end
  end

  assign rise    = s0 & ~s1_q & rdy_q;
  assign capture = rise & activate;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cap_q   <= 8'd0;
      delta_q <= 8'd0;
      ref_q   <= 8'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      delta_q <= delta_d;
      ref_q   <= ref_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    delta_d = delta_q;
    ref_d   = ref_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          ref_d   = cpt;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (capture) begin
          cap_d   = cpt;
          delta_d = cpt - ref_q;
          ref_d   = cpt;
          valid_d = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (capture) begin
          cap_d   = cpt;
          delta_d = cpt - ref_q;
          ref_d   = cpt;
          if (!rd) ovr_d = 1'b1;
        end else if (rd) begin
          valid_d = 1'b0;
          ovr_d   = 1'b0;
          state_d = S_ARMED;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cap   = cap_q;
  assign delta = delta_q;
  assign valid = valid_q;
  assign ovr   = ovr_q;

endmodule

// File: tb/tb_cpt_capture8.sv
// Self-checking bench for cpt_capture8: per-cycle vector table plus reset/re-arm sequence.
module tb_cpt_capture8;

`ifdef CPT_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       activate;
  logic [7:0] cpt;
  logic       evt;
  logic       rd;
  logic [7:0] cap;
  logic [7:0] delta;
  logic       valid;
  logic       ovr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       act;
    logic       evt;
    logic       rd;
    logic [7:0] cpt;
    logic [7:0] cap;
    logic [7:0] delta;
    logic       valid;
    logic       ovr;
  } vec_t;

  vec_t vq[$];

  cpt_capture8 dut (
    .clk      (clk),
    .reset    (reset),
    .activate (activate),
    .cpt      (cpt),
    .evt      (evt),
    .rd       (rd),
    .cap      (cap),
    .delta    (delta),
    .valid    (valid),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] c, input logic [7:0] d,
                           input logic v, input logic o);
    chk({tag, ".cap"}, cap, c);
    chk({tag, ".delta"}, delta, d);
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
    chk({tag, ".ovr"}, {7'd0, ovr}, {7'd0, o});
  endtask

  task automatic step(input logic a, input logic e, input logic r, input logic [7:0] c);
    @(negedge clk);
    activate = a;
    evt      = e;
    rd       = r;
    cpt      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic a, input logic e, input logic r, input logic [7:0] c,
                     input logic [7:0] ec, input logic [7:0] ed, input logic ev, input logic eo);
    vec_t v;
    v.act = a; v.evt = e; v.rd = r; v.cpt = c;
    v.cap = ec; v.delta = ed; v.valid = ev; v.ovr = eo;
    vq.push_back(v);
  endtask

  // evt low for LAT+1 cycles, then high for LAT+1 cycles; the capture lands with cpt = c + LAT
  task automatic pulse(input logic [7:0] c);
    for (int k = 0; k <= LAT; k++) step(1'b1, 1'b0, 1'b0, c - 8'(LAT + 1) + 8'(k));
    for (int k = 0; k <= LAT; k++) step(1'b1, 1'b1, 1'b0, c + 8'(k));
  endtask

  initial begin
    reset    = 1'b1;
    activate = 1'b0;
    evt      = 1'b0;
    rd       = 1'b0;
    cpt      = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

`ifndef CPT_CAPTURE_SYNC_EN
    //  act   evt   rd    cpt     cap     delta   valid ovr
    add(1'b1, 1'b0, 1'b0, 8'd1,   8'd0,   8'd0,   1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'd2,   8'd0,   8'd0,   1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd3,   8'd0,   8'd0,   1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd4,   8'd0,   8'd0,   1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'd5,   8'd0,   8'd0,   1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd13,  8'd13,  8'd10,  1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'd14,  8'd13,  8'd10,  1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'd15,  8'd13,  8'd10,  1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'd16,  8'd13,  8'd10,  1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd250, 8'd250, 8'd237, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'd251, 8'd250, 8'd237, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd4,   8'd4,   8'd10,  1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'd5,   8'd4,   8'd10,  1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd20,  8'd20,  8'd16,  1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 8'd21,  8'd20,  8'd16,  1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b1, 8'd22,  8'd20,  8'd16,  1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd30,  8'd30,  8'd10,  1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'd31,  8'd30,  8'd10,  1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 8'd37,  8'd37,  8'd7,   1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'd38,  8'd37,  8'd7,   1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'd40,  8'd37,  8'd7,   1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'd41,  8'd37,  8'd7,   1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd45,  8'd45,  8'd8,   1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 8'd46,  8'd45,  8'd8,   1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'd47,  8'd45,  8'd8,   1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'd50,  8'd45,  8'd8,   1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd51,  8'd45,  8'd8,   1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'd52,  8'd45,  8'd8,   1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd60,  8'd60,  8'd15,  1'b1, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].act, vq[i].evt, vq[i].rd, vq[i].cpt);
      check_all($sformatf("vec%0d", i), vq[i].cap, vq[i].delta, vq[i].valid, vq[i].ovr);
    end
`endif

    // async reset while evt is high must clear everything without waiting for a clock
    step(1'b1, 1'b0, 1'b0, 8'd61);
    @(negedge clk);
    evt   = 1'b1;
    reset = 1'b1;
    #1;
    check_all("rst_async", 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 8'd70 + 8'(k));
    check_all("rst_evt_held", 8'd0, 8'd0, 1'b0, 1'b0);

    pulse(8'd100);
    check_all("rearm_only", 8'd0, 8'd0, 1'b0, 1'b0);
    pulse(8'd110);
    check_all("after_rearm", 8'd110 + 8'(LAT), 8'd10, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'd120);
    check_all("read_clear", 8'd110 + 8'(LAT), 8'd10, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
